// File: rtl/lcd_timed_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lcd_timed_controller                                       |
// | Description : HD44780-class character LCD controller. Bus writes are     |
// |               queued in a {rs, byte} FIFO. A sequencer replays each      |
// |               entry on the LCD pins with programmed setup / E-high /     |
// |               hold widths followed by a post-command delay. Supports     |
// |               8-bit and 4-bit (LCD_data[7:4]) bus modes.                 |
// | Ports       : clk, reset      - clock, synchronous active-high reset     |
// |               address         - 0 cmd, 1 status, 2 data, 3 clear ovf     |
// |               write/writedata - single-cycle write strobe and byte       |
// |               read/readdata   - single-cycle read, data next cycle       |
// |               LCD_E/RS/RW     - registered LCD control (RW tied 0)       |
// |               LCD_data        - registered LCD bus                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lcd_timed_controller #(
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 12,
  parameter int HOLD_CYCLES   = 2,
  parameter int CMD_DELAY     = 2000,
  parameter int CLEAR_DELAY   = 82000,
  parameter int FIFO_DEPTH    = 16,
  parameter int BUS_4BIT      = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       write,
  input  logic [7:0] writedata,
  input  logic       read,
  output logic [7:0] readdata,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_data
);

  // Shared down-counter must hold the largest programmed interval.
  localparam int MAX_SE   = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
  localparam int MAX_SEH  = (MAX_SE > HOLD_CYCLES) ? MAX_SE : HOLD_CYCLES;
  localparam int MAX_SEHC = (MAX_SEH > CMD_DELAY) ? MAX_SEH : CMD_DELAY;
  localparam int MAX_ALL  = (MAX_SEHC > CLEAR_DELAY) ? MAX_SEHC : CLEAR_DELAY;
  localparam int CNT_W    = $clog2(MAX_ALL + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_EHIGH = CNT_W'(E_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CMD   = CNT_W'(CMD_DELAY - 1);
  localparam logic [CNT_W-1:0] C_CLEAR = CNT_W'(CLEAR_DELAY - 1);
  localparam logic [4:0]       C_DEPTH = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    readdata_q, readdata_d;

  // Sequencer
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       entry_q, entry_d;
  logic             lo_nib_q, lo_nib_d;   // 4-bit mode: low nibble in flight
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;

  logic       w_push, w_pop, w_full, w_push_ok, w_busy, w_is_clear;
  logic [8:0] w_head;

  assign w_push    = write && ((address == 2'd0) || (address == 2'd2));
  assign w_full    = (count_q == C_DEPTH);
  assign w_pop     = (state_q == ST_IDLE) && (count_q != 5'd0);
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_head    = mem_q[rptr_q];
  assign w_busy    = (state_q != ST_IDLE) || (count_q != 5'd0);
  // Clear display / return home (and the 0x00 no-op) need the long delay.
  assign w_is_clear = !entry_q[8] && (entry_q[7:2] == 6'd0);

  always_comb begin
    count_d = count_q;
    unique case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (w_push && !w_push_ok) begin
      ovf_d = 1'b1;
    end else if (write && (address == 2'd3)) begin
      ovf_d = 1'b0;
    end

    readdata_d = 8'h00;
    if (read && (address == 2'd1)) begin
      readdata_d = {ovf_q, w_busy, 1'b0, count_q};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    entry_d  = entry_q;
    lo_nib_d = lo_nib_q;
    e_d      = 1'b0;
    rs_d     = rs_q;
    data_d   = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (w_pop) begin
          entry_d  = w_head;
          lo_nib_d = 1'b0;
          rs_d     = w_head[8];
          data_d   = (BUS_4BIT != 0) ? {w_head[7:4], 4'h0} : w_head[7:0];
          cnt_d    = C_SETUP;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          e_d     = 1'b1;         // E is registered: raise it one cycle early
          cnt_d   = C_EHIGH;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = C_HOLD;
          state_d = ST_HOLD;
        end else begin
          e_d   = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          if ((BUS_4BIT != 0) && !lo_nib_q) begin
            lo_nib_d = 1'b1;
            data_d   = {entry_q[3:0], 4'h0};
            cnt_d    = C_SETUP;
            state_d  = ST_SETUP;
          end else begin
            cnt_d   = w_is_clear ? C_CLEAR : C_CMD;
            state_d = ST_WAIT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      entry_q    <= '0;
      lo_nib_q   <= 1'b0;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= 5'd0;
      ovf_q      <= 1'b0;
      readdata_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      entry_q    <= entry_d;
      lo_nib_q   <= lo_nib_d;
      e_q        <= e_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      readdata_q <= readdata_d;
      if (w_push_ok) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (w_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wptr_q] <= {address[1], writedata};
    end
  end

  assign readdata = readdata_q;
  assign LCD_E    = e_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timed_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lcd_timed_controller                                    |
// | Description : Bench for lcd_timed_controller. Three instances: 8-bit     |
// |               with a 4-deep FIFO and short timing, 4-bit with short      |
// |               timing, and one at default parameters. A per-instance      |
// |               reference predicts every E pulse (time, RS, data) and      |
// |               every status read from queue occupancy and timing sums.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_lcd_timed_controller;

  localparam int NI = 3;

  typedef struct {
    int       rise;
    bit       rs;
    bit [7:0] dat;
  } pulse_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_s  [NI];
  logic [1:0] addr_s [NI];
  logic       wr_s   [NI];
  logic [7:0] wd_s   [NI];
  logic       rd_s   [NI];
  logic [7:0] rdata_w[NI];
  logic       e_w    [NI];
  logic       rs_w   [NI];
  logic       rw_w   [NI];
  logic [7:0] data_w [NI];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S     = (g == 0) ? 3 : 2;
    localparam int E     = (g == 0) ? 4 : 12;
    localparam int H     = (g == 0) ? 1 : 2;
    localparam int CMD   = (g == 0) ? 30 : ((g == 1) ? 60 : 2000);
    localparam int CLR   = (g == 0) ? 100 : ((g == 1) ? 120 : 82000);
    localparam int DEPTH = (g == 0) ? 4 : ((g == 1) ? 8 : 16);
    localparam int B4    = (g == 1) ? 1 : 0;

    lcd_timed_controller #(
      .SETUP_CYCLES (S),
      .E_HIGH_CYCLES(E),
      .HOLD_CYCLES  (H),
      .CMD_DELAY    (CMD),
      .CLEAR_DELAY  (CLR),
      .FIFO_DEPTH   (DEPTH),
      .BUS_4BIT     (B4)
    ) u_dut (
      .clk      (clk),
      .reset    (rst_s[g]),
      .address  (addr_s[g]),
      .write    (wr_s[g]),
      .writedata(wd_s[g]),
      .read     (rd_s[g]),
      .readdata (rdata_w[g]),
      .LCD_E    (e_w[g]),
      .LCD_RS   (rs_w[g]),
      .LCD_RW   (rw_w[g]),
      .LCD_data (data_w[g])
    );

    // Reference state: queued entries, expected pulses, time the sequencer frees up.
    pulse_t   pq[$];
    bit [8:0] fq[$];
    int       free_at = 0;
    bit       ovf = 1'b0;
    bit       rd_pend = 1'b0;
    bit [7:0] rd_exp = 8'h00;
    bit       e_prev = 1'b0;
    bit       cut = 1'b0;
    bit       chk_low = 1'b0;
    int       hi_len = 0;
    int       nrise = 0;
    bit [7:0] rise_dat = 8'h00;
    int       t, n, nb;
    bit [7:0] status;
    bit       popn;
    bit [8:0] ent;
    pulse_t   p;

    always begin
      @(posedge clk);
      t = cyc;
      if (rst_s[g]) begin
        fq.delete();
        ovf     = 1'b0;
        free_at = t + 1;
        rd_pend = 1'b0;
        cut     = 1'b1;
        chk_low = 1'b1;
        while (pq.size() > 0 && pq[pq.size()-1].rise > t) pq.delete(pq.size() - 1);
      end else begin
        n       = fq.size();
        status  = {ovf, (n != 0) || (t < free_at), 1'b0, 5'(n)};
        rd_pend = rd_s[g];
        rd_exp  = (addr_s[g] == 2'd1) ? status : 8'h00;
        popn    = (t >= free_at) && (n > 0);
        if (wr_s[g] && addr_s[g] == 2'd3) ovf = 1'b0;
        if (popn) begin
          ent = fq.pop_front();
          nb  = (B4 != 0) ? 2 : 1;
          for (int k = 0; k < nb; k++) begin
            p.rise = t + 1 + S + k * (S + E + H);
            p.rs   = ent[8];
            if (B4 != 0) p.dat = (k == 0) ? {ent[7:4], 4'h0} : {ent[3:0], 4'h0};
            else         p.dat = ent[7:0];
            pq.push_back(p);
          end
          free_at = t + 1 + nb * (S + E + H) + ((!ent[8] && ent[7:0] < 8'd4) ? CLR : CMD);
        end
        if (wr_s[g] && (addr_s[g] == 2'd0 || addr_s[g] == 2'd2)) begin
          if (n < DEPTH || popn) fq.push_back({addr_s[g] == 2'd2, wd_s[g]});
          else ovf = 1'b1;
        end
      end

      @(negedge clk);
      if (chk_low) begin
        chk($sformatf("rst_E[%0d]", g), e_w[g], 0);
        chk($sformatf("rst_RS[%0d]", g), rs_w[g], 0);
        chk($sformatf("rst_data[%0d]", g), data_w[g], 0);
        chk_low = 1'b0;
      end
      if (rd_pend) chk($sformatf("readdata[%0d]", g), rdata_w[g], rd_exp);
      if (e_w[g] && !e_prev) begin
        nrise++;
        hi_len   = 1;
        cut      = 1'b0;
        rise_dat = data_w[g];
        if (pq.size() == 0) begin
          chk($sformatf("spurious_E[%0d]", g), 1, 0);
        end else begin
          p = pq.pop_front();
          chk($sformatf("E_rise_cycle[%0d]", g), cyc, p.rise);
          chk($sformatf("E_RS[%0d]", g), rs_w[g], p.rs);
          chk($sformatf("E_data[%0d]", g), data_w[g], p.dat);
        end
        chk($sformatf("RW[%0d]", g), rw_w[g], 0);
      end else if (e_w[g]) begin
        hi_len++;
      end else if (e_prev && !cut) begin
        chk($sformatf("E_width[%0d]", g), hi_len, E);
        chk($sformatf("hold_data[%0d]", g), data_w[g], rise_dat);
      end
      e_prev = e_w[g];
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic bus_wr(input int g, input logic [1:0] a, input logic [7:0] d);
    addr_s[g] = a; wd_s[g] = d; wr_s[g] = 1'b1;
    @(negedge clk);
    wr_s[g] = 1'b0;
  endtask

  task automatic bus_rd(input int g, input logic [1:0] a);
    addr_s[g] = a; rd_s[g] = 1'b1;
    @(negedge clk);
    rd_s[g] = 1'b0;
  endtask

  task automatic rand_op(input int g);
    int r;
    r = $urandom_range(0, 399);
    addr_s[g] = 2'($urandom_range(0, 3));
    wd_s[g]   = 8'($urandom_range(0, 255));
    if (r == 0) begin
      rst_s[g] = 1'b1;
    end else if (r <= 8) begin
      addr_s[g] = 2'd0; wr_s[g] = 1'b1;
      if ($urandom_range(0, 3) == 0) wd_s[g] = 8'($urandom_range(0, 3));
    end else if (r <= 16) begin
      addr_s[g] = 2'd2; wr_s[g] = 1'b1;
    end else if (r <= 40) begin
      rd_s[g] = 1'b1;
    end else if (r <= 42) begin
      addr_s[g] = 2'd1; wr_s[g] = 1'b1;
    end else if (r <= 44) begin
      addr_s[g] = 2'd3; wr_s[g] = 1'b1;
    end
  endtask

  int t0, n0, lim;

  initial begin
    for (int g = 0; g < NI; g++) begin
      rst_s[g] = 1'b1; addr_s[g] = 2'd0; wr_s[g] = 1'b0; wd_s[g] = 8'h00; rd_s[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) rst_s[g] = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_readdata[%0d]", g), rdata_w[g], 0);
      chk($sformatf("rst_RW[%0d]", g), rw_w[g], 0);
    end
    for (int g = 0; g < NI; g++) begin
      bus_rd(g, 2'd1);
      chk($sformatf("rst_status[%0d]", g), rdata_w[g], 8'h00);
    end

    // Default timing: command 0x38
    t0 = cyc;
    bus_wr(2, 2'd0, 8'h38);
    wait_cyc(t0 + 2);
    chk("cmd38_RS", rs_w[2], 0);
    chk("cmd38_data", data_w[2], 8'h38);
    chk("cmd38_E_setup", e_w[2], 0);
    wait_cyc(t0 + 4);  chk("cmd38_E_first", e_w[2], 1);
    wait_cyc(t0 + 15); chk("cmd38_E_last", e_w[2], 1);
    wait_cyc(t0 + 16); chk("cmd38_E_fall", e_w[2], 0);
    wait_cyc(t0 + 2017);
    bus_rd(2, 2'd1);
    chk("cmd38_busy", rdata_w[2], 8'h40);
    bus_rd(2, 2'd1);
    chk("cmd38_done", rdata_w[2], 8'h00);

    // 8-bit: clear display then data 0x41
    bus_wr(0, 2'd0, 8'h01);
    bus_wr(0, 2'd2, 8'h41);
    repeat (400) @(negedge clk);

    // Overflow on the 4-deep FIFO
    n0 = g_dut[0].nrise;
    for (int i = 0; i < 6; i++) bus_wr(0, 2'd2, 8'(8'h30 + i));
    bus_rd(0, 2'd1);
    chk("ovf_status", rdata_w[0], 8'hC4);
    bus_wr(0, 2'd3, 8'h00);
    bus_rd(0, 2'd1);
    chk("ovf_cleared", rdata_w[0], 8'h44);
    repeat (300) @(negedge clk);
    chk("ovf_transfers", g_dut[0].nrise - n0, 5);

    // 4-bit: data 0xA5 then 0x3C
    bus_wr(1, 2'd2, 8'hA5);
    bus_wr(1, 2'd2, 8'h3C);
    repeat (300) @(negedge clk);

    // Reset while E is high, with a second entry still queued
    bus_wr(1, 2'd0, 8'h38);
    bus_wr(1, 2'd2, 8'h55);
    lim = 0;
    while (!e_w[1] && lim < 60) begin @(negedge clk); lim++; end
    chk("rst_wait_E", e_w[1], 1);
    rst_s[1] = 1'b1;
    @(negedge clk);
    rst_s[1] = 1'b0;
    chk("rst_midpulse_E", e_w[1], 0);
    n0 = g_dut[1].nrise;
    bus_rd(1, 2'd1);
    chk("rst_midpulse_status", rdata_w[1], 8'h00);
    repeat (300) @(negedge clk);
    chk("rst_no_pulses", g_dut[1].nrise - n0, 0);

    // Randomised traffic on the short-timing instances
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < 2; g++) rand_op(g);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        wr_s[g] = 1'b0; rd_s[g] = 1'b0; rst_s[g] = 1'b0;
      end
    end
    repeat (1500) @(negedge clk);
    chk("drain_pending[0]", g_dut[0].pq.size(), 0);
    chk("drain_pending[1]", g_dut[1].pq.size(), 0);
    chk("drain_pending[2]", g_dut[2].pq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
